mm_job_scheduler: RTL

//  Top-level sequencer for one Montgomery multiplication job: accepts a host job request, then runs
//  the memory load phase, the FIOS compute phase and the memory store phase in order. It watches

---
 rtl/mm_pkg.sv | 31 +++
 rtl/phase_watchdog.sv | 38 +++
 rtl/mm_job_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the Montgomery multiplication job scheduler.
package mm_pkg;

    // Scheduler phases, in the order a nominal job walks through them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_STORE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } sched_state_t;

    // Reason recorded on entry to ERROR.
    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_TIMEOUT     = 2'd1,
        ERR_EXCESS_PUSH = 2'd2,
        ERR_UNEXP_DONE  = 2'd3
    } err_code_t;

    // Memory operation direction, shared with memory_control.
    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    // Phases during which the datapath is working and the watchdog is armed.
    function automatic logic is_busy(sched_state_t st);
        return (st == ST_LOAD) || (st == ST_COMPUTE) || (st == ST_STORE);
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase watchdog: counts idle cycles since the last load/kick and flags
// when the count reaches TIMEOUT-1. The count holds there instead of wrapping.
module phase_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic kick_i,
    output logic expire_o
);
    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Restart on phase entry or activity, otherwise count up to the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i || kick_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mm_job_scheduler.sv
// Job sequencer: IDLE -> LOAD -> COMPUTE -> STORE -> DONE, with a per-phase
// watchdog, result-block counting, protocol error trapping and a saturating
// job cycle counter.
module mm_job_scheduler
    import mm_pkg::*;
#(
    parameter int s       = 16,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic             clear_i,
    output logic             mem_start_o,
    output logic             mem_load_store_o,
    input  logic             mem_load_done_i,
    input  logic             mem_store_done_i,
    output logic             fios_start_o,
    input  logic             res_push_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] job_cycles_o
);
    localparam int RES_W = $clog2(s + 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(s - 1);
    localparam logic [CNT_W-1:0] CYC_MAX  = '1;

    sched_state_t     state_q, state_d;
    err_code_t        err_q, err_d;
    logic [RES_W-1:0] res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             mem_start_q, mem_start_d;
    logic             fios_start_q, fios_start_d;
    err_code_t        det;
    logic             wd_expire;
    logic             wd_load;

    // Every state change restarts the watchdog; each result block kicks it.
    assign wd_load = (state_d != state_q);

    phase_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .load_i   (wd_load),
        .kick_i   (res_push_i),
        .expire_o (wd_expire)
    );

    // Next state: protocol errors first, then the normal phase advance,
    // then watchdog expiry. Start pulses are registered so they land in the
    // first cycle of the new phase.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        res_cnt_d    = res_cnt_q;
        cyc_d        = cyc_q;
        mem_start_d  = 1'b0;
        fios_start_d = 1'b0;
        det          = ERR_NONE;

        if (state_q != ST_ERROR) begin
            if (res_push_i && (state_q != ST_COMPUTE)) begin
                det = ERR_EXCESS_PUSH;
            end else if ((mem_load_done_i && (state_q != ST_LOAD)) ||
                         (mem_store_done_i && (state_q != ST_STORE))) begin
                det = ERR_UNEXP_DONE;
            end
        end

        // Job length covers every cycle from LOAD through DONE.
        if (is_busy(state_q) || (state_q == ST_DONE)) begin
            if (cyc_q != CYC_MAX) cyc_d = cyc_q + CNT_W'(1);
        end

        if (det != ERR_NONE) begin
            state_d = ST_ERROR;
            err_d   = det;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (job_valid_i) begin
                        state_d     = ST_LOAD;
                        cyc_d       = '0;
                        mem_start_d = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (mem_load_done_i) begin
                        state_d      = ST_COMPUTE;
                        res_cnt_d    = '0;
                        fios_start_d = 1'b1;
                    end else if (wd_expire) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                ST_COMPUTE: begin
                    // A push is proof of progress, so it outranks a
                    // simultaneous expiry. The counter leaves COMPUTE on the
                    // s-th block and so never wraps.
                    if (res_push_i) begin
                        res_cnt_d = res_cnt_q + RES_W'(1);
                        if (res_cnt_q == RES_LAST) begin
                            state_d     = ST_STORE;
                            mem_start_d = 1'b1;
                        end
                    end else if (wd_expire) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                ST_STORE: begin
                    if (mem_store_done_i) begin
                        state_d = ST_DONE;
                    end else if (wd_expire) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                ST_ERROR: begin
                    if (clear_i) begin
                        state_d = ST_IDLE;
                        err_d   = ERR_NONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers; reset aborts any job in flight.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_NONE;
            res_cnt_q    <= '0;
            cyc_q        <= '0;
            mem_start_q  <= 1'b0;
            fios_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            res_cnt_q    <= res_cnt_d;
            cyc_q        <= cyc_d;
            mem_start_q  <= mem_start_d;
            fios_start_q <= fios_start_d;
        end
    end

    assign job_ready_o      = (state_q == ST_IDLE);
    assign busy_o           = is_busy(state_q);
    assign done_o           = (state_q == ST_DONE);
    assign error_o          = (state_q == ST_ERROR);
    assign err_code_o       = err_q;
    assign mem_start_o      = mem_start_q;
    assign fios_start_o     = fios_start_q;
    assign mem_load_store_o = (state_q == ST_STORE) ? LS_STORE : LS_LOAD;
    assign job_cycles_o     = cyc_q;

endmodule
